// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM encoding and the digit-count sanity helper.
package bin_to_bcd_seq_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of decimal digits needed to show the largest w-bit value.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        int              digits;
        max_val = (longint'(1) << width) - 1;
        digits  = 1;
        while (max_val >= 10) begin
            max_val = max_val / 10;
            digits  = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Result-word input and BCD output bundle of the converter.
// The master side feeds binary words, the slave side is the converter.
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int w  = 8,
    parameter int nd = 3
);
    logic                    bin_vld;
    logic [w-1:0]            bin;
    logic                    bcd_vld;
    logic [DIGIT_W*nd-1:0]   bcd;
    logic                    busy;
    logic                    ovf;

    modport master (
        output bin_vld, bin,
        input  bcd_vld, bcd, busy, ovf
    );

    modport slave (
        input  bin_vld, bin,
        output bcd_vld, bcd, busy, ovf
    );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a single-entry pending slot so back-to-back input words are not lost.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int w  = 8,
    parameter int nd = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * nd;
    localparam int SR_W  = BCD_W + w;
    localparam int CNT_W = (w > 1) ? $clog2(w) : 1;

    if (nd < min_digits(w)) begin : g_nd_check
        $error("bin_to_bcd_seq: nd too small for input width w");
    end

    state_t              state_reg, state_next;
    logic [SR_W-1:0]     sr_reg, sr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [w-1:0]        pend_reg, pend_next;
    logic                pend_vld_reg, pend_vld_next;
    logic [BCD_W-1:0]    bcd_reg, bcd_next;
    logic                bcd_vld_reg, bcd_vld_next;
    logic                ovf_reg, ovf_next;

    logic [BCD_W-1:0]    digits_adj;
    logic [SR_W-1:0]     sr_shifted;
    logic                is_final;

    for (genvar gi = 0; gi < nd; gi++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_in  (sr_reg[w + DIGIT_W*gi +: DIGIT_W]),
            .digit_out (digits_adj[DIGIT_W*gi +: DIGIT_W])
        );
    end

    // The bit shifted out of the top digit is always zero given enough digits.
    assign sr_shifted = {digits_adj, sr_reg[w-1:0]} << 1;
    assign is_final   = (state_reg == SHIFT) && (cnt_reg == CNT_W'(w - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sr_reg       <= '0;
            cnt_reg      <= '0;
            pend_reg     <= '0;
            pend_vld_reg <= 1'b0;
            bcd_reg      <= '0;
            bcd_vld_reg  <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            cnt_reg      <= cnt_next;
            pend_reg     <= pend_next;
            pend_vld_reg <= pend_vld_next;
            bcd_reg      <= bcd_next;
            bcd_vld_reg  <= bcd_vld_next;
            ovf_reg      <= ovf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        cnt_next      = cnt_reg;
        pend_next     = pend_reg;
        pend_vld_next = pend_vld_reg;
        bcd_next      = bcd_reg;
        bcd_vld_next  = 1'b0;
        ovf_next      = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (bus.bin_vld) begin
                    sr_next    = {{BCD_W{1'b0}}, bus.bin};
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (!is_final) begin
                    sr_next  = sr_shifted;
                    cnt_next = cnt_reg + 1'b1;
                    if (bus.bin_vld) begin
                        pend_next     = bus.bin;
                        pend_vld_next = 1'b1;
                        if (pend_vld_reg) begin
                            ovf_next = 1'b1;
                        end
                    end
                end else begin
                    bcd_next     = sr_shifted[SR_W-1:w];
                    bcd_vld_next = 1'b1;
                    cnt_next     = '0;
                    // A waiting word has priority; a new word then takes its slot.
                    if (pend_vld_reg) begin
                        sr_next = {{BCD_W{1'b0}}, pend_reg};
                        if (bus.bin_vld) begin
                            pend_next     = bus.bin;
                            pend_vld_next = 1'b1;
                        end else begin
                            pend_vld_next = 1'b0;
                        end
                    end else if (bus.bin_vld) begin
                        sr_next = {{BCD_W{1'b0}}, bus.bin};
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.bcd     = bcd_reg;
    assign bus.bcd_vld = bcd_vld_reg;
    assign bus.busy    = (state_reg == SHIFT);
    assign bus.ovf     = ovf_reg;

endmodule
